// File: rtl/rot_arbiter.sv
// Round-robin arbiter sharing one 4-bit left-rotate datapath among NREQ requesters.
// Latency: one cycle from req handshake to out_valid; one result per cycle sustained.
// Backpressure: result held while out_ready=0, and req_ready stays low until the slot frees.
// Optional: define ROT_ARBITER_STATS_EN to add grant_cnt / stall_cnt outputs.
module rot_arbiter #(
  parameter int NREQ = 2,
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_data,
  input  logic [2*NREQ-1:0] req_shift,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  output logic [3:0]        out_data,
  output logic [ID_W-1:0]   out_id,
`ifdef ROT_ARBITER_STATS_EN
  output logic [15:0]       grant_cnt,
  output logic [15:0]       stall_cnt,
`endif
  input  logic              out_ready
);

  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_found;
  logic            slot_free;
  logic            xfer;
  logic [3:0]      sel_data;
  logic [1:0]      sel_shift;
  logic [3:0]      rotated;

  assign out_valid = (state == FULL);
  assign slot_free = (state == IDLE) | (out_valid & out_ready);
  // A grant is never issued during reset, so the reset cycle cannot transfer.
  assign xfer      = slot_free & gnt_found & ~rst;

  // Round-robin search starting just after the last winner, wrapping around.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx[ID_W-1:0];
      end
    end
  end

  // One-hot accept on the winner only when the result slot can take it.
  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[gnt_idx] = 1'b1;
  end

  // Select the winner's command and left-rotate it.
  always_comb begin
    sel_data  = req_data[4*gnt_idx +: 4];
    sel_shift = req_shift[2*gnt_idx +: 2];
    case (sel_shift)
      2'd0:    rotated = sel_data;
      2'd1:    rotated = {sel_data[2:0], sel_data[3]};
      2'd2:    rotated = {sel_data[1:0], sel_data[3:2]};
      default: rotated = {sel_data[0], sel_data[3:1]};
    endcase
  end

  // Next state: a new transfer always refills; a drain without refill empties.
  always_comb begin
    state_nxt = state;
    if (xfer) begin
      state_nxt = FULL;
    end else if (state == FULL && out_ready) begin
      state_nxt = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Result register and round-robin pointer; both only move on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data   <= '0;
      out_id     <= '0;
      last_grant <= ID_W'(NREQ - 1);
    end else if (xfer) begin
      out_data   <= rotated;
      out_id     <= gnt_idx;
      last_grant <= gnt_idx;
    end
  end

`ifdef ROT_ARBITER_STATS_EN
  // Grant count wraps; stall count saturates so long stalls stay visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (xfer) grant_cnt <= grant_cnt + 16'd1;
      if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rot_arbiter.sv
module tb_rot_arbiter;

  localparam int NREQ = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [7:0] req_data;
  logic [3:0] req_shift;
  logic [1:0] req_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_id;
  logic       out_ready;

  int checks   = 0;
  int failures = 0;

  // expected results: {id, data}
  logic [4:0] sb[$];

  rot_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_shift (req_shift),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] mrot(input logic [3:0] d, input logic [1:0] s);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = d[(i - int'(s) + 4) % 4];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: push on handshake, pop/compare on consumption.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_out", {27'd0, out_id, out_data}, 32'h1f);
        end else begin
          logic [4:0] e;
          e = sb.pop_front();
          chk("sb_out", {27'd0, out_id, out_data}, {27'd0, e});
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i])
          sb.push_back({i[0], mrot(req_data[4*i +: 4], req_shift[2*i +: 2])});
      end
    end
  end

  initial begin
    logic [3:0] rtab [4];
    rtab[0] = 4'b1011; rtab[1] = 4'b0111; rtab[2] = 4'b1110; rtab[3] = 4'b1101;

    // Reset with both requesters asserting: nothing may be accepted.
    rst = 1'b1; req_valid = 2'b11; req_data = 8'h00; req_shift = 4'h0; out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_req_ready", req_ready, 0);

    // Single request from requester 0.
    rst = 1'b0; req_valid = 2'b01; req_data = 8'h01; req_shift = 4'h1;
    #1 chk("single_req_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("single_out_valid", out_valid, 1);
    chk("single_out_data", out_data, 4'b0010);
    chk("single_out_id", out_id, 0);
    tick();
    chk("single_drain_idle", out_valid, 0);

    // Rotate table on requester 1, back to back.
    req_data = 8'hB0;
    for (int s = 0; s < 4; s++) begin
      req_valid = 2'b10; req_shift = {s[1:0], 2'b00};
      tick();
      chk($sformatf("rot_data_s%0d", s), out_data, rtab[s]);
      chk($sformatf("rot_id_s%0d", s), out_id, 1);
    end
    req_valid = 2'b00;
    tick();
    chk("rot_idle", out_valid, 0);

    // Round robin with both requesters always valid.
    req_valid = 2'b11; req_data = 8'h96; req_shift = 4'hE;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("rr_ready_%0d", k), req_ready, (k % 2) ? 2'b10 : 2'b01);
      tick();
      chk($sformatf("rr_valid_%0d", k), out_valid, 1);
      chk($sformatf("rr_id_%0d", k), out_id, k % 2);
    end
    req_valid = 2'b00;
    tick();

    // Backpressure: result held while requester 1 waits.
    req_valid = 2'b01; req_data = 8'h95; req_shift = 4'hD; out_ready = 1'b0;
    #1 chk("bp_first_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_data_%0d", c), out_data, 4'b1010);
      chk($sformatf("bp_id_%0d", c), out_id, 0);
      chk($sformatf("bp_ready_%0d", c), req_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    chk("bp_next_id", out_id, 1);
    chk("bp_next_data", out_data, 4'b1100);
    chk("bp_next_valid", out_valid, 1);
    tick();

    // Reset while holding a result.
    req_valid = 2'b10; out_ready = 1'b0;
    tick();
    chk("mid_full", out_valid, 1);
    rst = 1'b1; req_valid = 2'b11;
    #1 chk("mid_rst_ready", req_ready, 0);
    tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    rst = 1'b0; out_ready = 1'b1;
    #1 chk("mid_after_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("mid_after_id", out_id, 0);
    tick();
    tick();
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
